// File: rtl/register_file_sb.sv
// Architectural integer register file with write bypass
// and a per-register pending-write scoreboard.
module register_file_sb #(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREGS-1:0] en,
  input  logic [DW-1:0]    wdat,
  input  logic [AW-1:0]    rsel1,
  input  logic [AW-1:0]    rsel2,
  output logic [DW-1:0]    rdat1,
  output logic [DW-1:0]    rdat2,
  input  logic             issue,
  input  logic [AW-1:0]    issue_sel,
  output logic             busy1,
  output logic             busy2,
  output logic             en_err
);

  logic [DW-1:0]    r_regs [NREGS];
  logic [NREGS-1:0] r_sb;
  logic             r_en_err;

  logic             w_multi;
  logic             w_legal;
  logic [NREGS-1:0] w_wen;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_sb_nxt;

  // More than one bit set: clearing the lowest set bit leaves something.
  // en[0] participates, so 0x21 is just as illegal as 0x300.
  assign w_multi = |(en & (en - NREGS'(1)));
  assign w_legal = !w_multi;

  // Effective per-register write strobes; register 0 never takes a write.
  always_comb begin
    w_wen    = '0;
    if (w_legal) begin
      w_wen  = en;
    end
    w_wen[0] = 1'b0;
  end

  // Scoreboard set vector from the issuing instruction's destination.
  always_comb begin
    w_set = '0;
    if (issue && (issue_sel != '0)) begin
      w_set[issue_sel] = 1'b1;
    end
  end

  // A legal write retires its producer; a same-cycle issue re-arms it.
  assign w_sb_nxt = (r_sb & ~w_wen) | w_set;

  // Register array update; reset overrides any concurrent write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_regs[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (w_wen[i]) begin
          r_regs[i] <= wdat;
        end
      end
    end
  end

  // Pending-write scoreboard state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  // Sticky illegal-enable flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_en_err <= 1'b0;
    end else if (w_multi) begin
      r_en_err <= 1'b1;
    end
  end

  // Read port 1: zero register, then bypass, then stored value.
  always_comb begin
    rdat1 = r_regs[rsel1];
    if (RST || (rsel1 == '0)) begin
      rdat1 = '0;
    end else if (w_wen[rsel1]) begin
      rdat1 = wdat;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdat2 = r_regs[rsel2];
    if (RST || (rsel2 == '0)) begin
      rdat2 = '0;
    end else if (w_wen[rsel2]) begin
      rdat2 = wdat;
    end
  end

  // Busy unless the pending result is being forwarded this cycle.
  always_comb begin
    busy1 = r_sb[rsel1] && !w_wen[rsel1] && !RST;
    busy2 = r_sb[rsel2] && !w_wen[rsel2] && !RST;
  end

  assign en_err = r_en_err;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: reset, bypass,
// zero register, illegal enable and scoreboard behaviour.
module tb_register_file_sb;

  logic        CLK;
  logic        RST;
  logic [31:0] en;
  logic [31:0] wdat;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic        issue;
  logic [4:0]  issue_sel;
  logic        busy1;
  logic        busy2;
  logic        en_err;

  int checks   = 0;
  int failures = 0;

  register_file_sb #(
    .NREGS(32),
    .DW   (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .wdat     (wdat),
    .rsel1    (rsel1),
    .rsel2    (rsel2),
    .rdat1    (rdat1),
    .rdat2    (rdat2),
    .issue    (issue),
    .issue_sel(issue_sel),
    .busy1    (busy1),
    .busy2    (busy2),
    .en_err   (en_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; en = '0; wdat = '0;
    rsel1 = '0; rsel2 = '0;
    issue = 1'b0; issue_sel = '0;
    step();
    RST = 1'b0;

    // Populate some state before the reset test.
    en = 32'h2; wdat = 32'h1111_1111; issue = 1'b1; issue_sel = 5'd4;
    step();
    en = 32'h4; wdat = 32'h2222_2222; issue = 1'b0;
    step();
    en = 32'h6; wdat = 32'h3333_3333;
    step();
    en = '0;
    rsel1 = 5'd1; rsel2 = 5'd2;
    #1;
    chk("pre_rst_r1", rdat1, 32'h1111_1111);
    chk("pre_rst_r2", rdat2, 32'h2222_2222);
    chk("pre_rst_err", {31'b0, en_err}, 32'd1);

    // Reset with a concurrent write and issue: reset wins.
    RST = 1'b1; en = 32'h2; wdat = 32'h9999_9999;
    issue = 1'b1; issue_sel = 5'd1;
    #1;
    chk("rst_during_r1", rdat1, 32'h0);
    step();
    RST = 1'b0; en = '0; issue = 1'b0;
    rsel1 = 5'd1; rsel2 = 5'd4;
    #1;
    chk("rst_r1", rdat1, 32'h0);
    chk("rst_r4", rdat2, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'd0);
    chk("rst_busy2", {31'b0, busy2}, 32'd0);
    chk("rst_err", {31'b0, en_err}, 32'd0);
    rsel1 = 5'd2;
    #1;
    chk("rst_r2", rdat1, 32'h0);

    // Same-cycle bypass, then the stored value.
    en = 32'h0000_0020; wdat = 32'hDEAD_BEEF; rsel1 = 5'd5;
    #1;
    chk("bypass_r5", rdat1, 32'hDEAD_BEEF);
    step();
    en = '0; wdat = 32'h0;
    #1;
    chk("stored_r5", rdat1, 32'hDEAD_BEEF);

    // Register 0 ignores writes and is legal to enable alone.
    en = 32'h0000_0001; wdat = 32'h1234;
    rsel1 = 5'd0; rsel2 = 5'd0;
    #1;
    chk("r0_bypass1", rdat1, 32'h0);
    chk("r0_bypass2", rdat2, 32'h0);
    step();
    en = '0;
    #1;
    chk("r0_after", rdat1, 32'h0);
    chk("r0_err", {31'b0, en_err}, 32'd0);

    // Seed regs 8/9 and put reg 8 in flight.
    en = 32'h100; wdat = 32'hAAAA_AAAA;
    step();
    en = 32'h200; wdat = 32'hBBBB_BBBB;
    issue = 1'b1; issue_sel = 5'd8;
    step();
    issue = 1'b0;
    en = 32'h0000_0300; wdat = 32'hFFFF_FFFF;
    rsel1 = 5'd8; rsel2 = 5'd9;
    #1;
    chk("ill_nobyp_r8", rdat1, 32'hAAAA_AAAA);
    chk("ill_nobyp_r9", rdat2, 32'hBBBB_BBBB);
    chk("ill_busy8", {31'b0, busy1}, 32'd1);
    step();
    en = '0;
    #1;
    chk("ill_r8", rdat1, 32'hAAAA_AAAA);
    chk("ill_r9", rdat2, 32'hBBBB_BBBB);
    chk("ill_err", {31'b0, en_err}, 32'd1);
    chk("ill_sb8_kept", {31'b0, busy1}, 32'd1);
    step();
    chk("ill_err_held", {31'b0, en_err}, 32'd1);

    // en[0] counts toward the popcount.
    en = 32'h0000_0021; wdat = 32'h5555_5555; rsel1 = 5'd5;
    #1;
    chk("ill0_nobyp", rdat1, 32'hDEAD_BEEF);
    step();
    en = '0;
    #1;
    chk("ill0_r5", rdat1, 32'hDEAD_BEEF);

    // A legal write finally retires reg 8.
    en = 32'h100; wdat = 32'h8888_8888; rsel1 = 5'd8;
    #1;
    chk("clr8_busy", {31'b0, busy1}, 32'd0);
    step();
    en = '0;
    #1;
    chk("clr8_after", {31'b0, busy1}, 32'd0);
    chk("clr8_r8", rdat1, 32'h8888_8888);

    // Issue to 7, then its writeback.
    issue = 1'b1; issue_sel = 5'd7; rsel1 = 5'd7;
    #1;
    chk("iss7_same", {31'b0, busy1}, 32'd0);
    step();
    issue = 1'b0;
    #1;
    chk("iss7_busy", {31'b0, busy1}, 32'd1);
    step();
    chk("iss7_hold", {31'b0, busy1}, 32'd1);
    en = 32'h80; wdat = 32'h7777_7777;
    #1;
    chk("wb7_busy", {31'b0, busy1}, 32'd0);
    chk("wb7_byp", rdat1, 32'h7777_7777);
    step();
    en = '0;
    #1;
    chk("wb7_after", {31'b0, busy1}, 32'd0);
    chk("wb7_r7", rdat1, 32'h7777_7777);

    // Issue and write to reg 3 together: set wins.
    issue = 1'b1; issue_sel = 5'd3;
    en = 32'h8; wdat = 32'h3333_0003; rsel2 = 5'd3;
    #1;
    chk("iw3_same", {31'b0, busy2}, 32'd0);
    chk("iw3_byp", rdat2, 32'h3333_0003);
    step();
    issue = 1'b0; en = '0;
    #1;
    chk("iw3_busy", {31'b0, busy2}, 32'd1);
    chk("iw3_r3", rdat2, 32'h3333_0003);

    // issue_sel 0 never marks anything busy.
    issue = 1'b1; issue_sel = 5'd0; rsel1 = 5'd0;
    step();
    issue = 1'b0;
    #1;
    chk("iss0_busy", {31'b0, busy1}, 32'd0);

    // Reset clears the sticky flag and scoreboard.
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("final_err", {31'b0, en_err}, 32'd0);
    chk("final_busy3", {31'b0, busy2}, 32'd0);
    chk("final_r3", rdat2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
